// File: rtl/lsm_address_generator_pkg.sv
// Shared definitions for the LDM/STM address sequencer: FSM state encoding,
// address step and instruction-register field positions.
package lsm_address_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } lsm_state_e;

  localparam int ADDR_STEP = 4;

  localparam int P_BIT     = 24;
  localparam int U_BIT     = 23;
  localparam int W_BIT     = 21;
  localparam int RLIST_MSB = 15;

endpackage : lsm_address_generator_pkg

// File: rtl/lsm_address_generator_popcount16.sv
// Combinational population count of a 16-bit register list (result 0..16).
module popcount16 (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);

  // NOTE: blocking assignments are correct here: this is combinational
  // accumulation, and o_count is given a default first so no latch is inferred.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 16; i++) begin
      o_count = o_count + {4'd0, i_data[i]};
    end
  end

endmodule : popcount16

// File: rtl/lsm_address_generator.sv
// LDM/STM memory-address sequencer: start address, per-transfer stepping and
// base write-back value. Optional abort input enabled by macro LSM_ABORT_EN.
module lsm_address_generator
  import lsm_address_generator_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LSM_START,
  input  logic [31:0]       IR,
  input  logic [ADDR_W-1:0] BASE,
`ifdef LSM_ABORT_EN
  input  logic              LSM_ABORT,
`endif
  input  logic              LSM_NEXT,
  output logic [ADDR_W-1:0] LSM_ADDR,
  output logic              LSM_XFER,
  output logic              LSM_LAST,
  output logic [ADDR_W-1:0] LSM_WB_VALUE,
  output logic              LSM_WB_EN,
  output logic              LSM_DONE,
  output logic              LSM_BUSY
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  lsm_state_e          r_state;
  logic [ADDR_W-1:0]   r_base;
  logic                r_p;
  logic                r_u;
  logic                r_w;
  logic [RLIST_MSB:0]  r_rlist;
  logic [4:0]          r_remaining;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_wb_value;
  logic                r_xfer;
  logic                r_last;
  logic                r_wb_en;
  logic                r_done;
  logic                r_busy;

  logic [4:0]          w_count;
  logic [ADDR_W-1:0]   w_span;
  logic [ADDR_W-1:0]   w_start_addr;
  logic [ADDR_W-1:0]   w_wb_value;
  logic                w_abort;
  logic                w_unused_ir;

`ifdef LSM_ABORT_EN
  assign w_abort = LSM_ABORT;
`else
  assign w_abort = 1'b0;
`endif

  // Only P, U, W and the register list matter to address generation.
  assign w_unused_ir = ^{IR[31:25], IR[22], IR[20:16]};

  popcount16 u_popcount (
    .i_data  (r_rlist),
    .o_count (w_count)
  );

  // Lowest register always sits at the lowest address, so every mode
  // reduces to a start offset from BASE followed by ascending steps.
  always_comb begin
    w_span = {{(ADDR_W-7){1'b0}}, w_count, 2'b00};
    unique case ({r_p, r_u})
      2'b01:   w_start_addr = r_base;
      2'b11:   w_start_addr = r_base + STEP;
      2'b00:   w_start_addr = r_base - w_span + STEP;
      default: w_start_addr = r_base - w_span;
    endcase
    w_wb_value = r_u ? (r_base + w_span) : (r_base - w_span);
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_p         <= 1'b0;
      r_u         <= 1'b0;
      r_w         <= 1'b0;
      r_rlist     <= '0;
      r_remaining <= '0;
      r_addr      <= '0;
      r_wb_value  <= '0;
      r_xfer      <= 1'b0;
      r_last      <= 1'b0;
      r_wb_en     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_wb_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (LSM_START) begin
            r_base  <= BASE;
            r_p     <= IR[P_BIT];
            r_u     <= IR[U_BIT];
            r_w     <= IR[W_BIT];
            r_rlist <= IR[RLIST_MSB:0];
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
          end
        end

        ST_CALC: begin
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_addr      <= w_start_addr;
            r_wb_value  <= w_wb_value;
            r_remaining <= w_count;
            if (w_count == 5'd0) begin
              r_done  <= 1'b1;
              r_wb_en <= r_w;
              r_state <= ST_DONE;
            end else begin
              r_xfer  <= 1'b1;
              r_last  <= (w_count == 5'd1);
              r_state <= ST_XFER;
            end
          end
        end

        ST_XFER: begin
          if (w_abort) begin
            r_xfer  <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (LSM_NEXT) begin
            r_addr      <= r_addr + STEP;
            r_remaining <= r_remaining - 5'd1;
            if (r_remaining == 5'd1) begin
              r_xfer  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_wb_en <= r_w;
              r_state <= ST_DONE;
            end else begin
              // LAST flags the transfer that will leave one remaining.
              r_last <= (r_remaining == 5'd2);
            end
          end
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign LSM_ADDR     = r_addr;
  assign LSM_XFER     = r_xfer;
  assign LSM_LAST     = r_last;
  assign LSM_WB_VALUE = r_wb_value;
  assign LSM_WB_EN    = r_wb_en;
  assign LSM_DONE     = r_done;
  assign LSM_BUSY     = r_busy;

endmodule : lsm_address_generator

// File: tb/tb_lsm_address_generator.sv
// Directed self-checking bench for lsm_address_generator (all P/U modes,
// wrap-around, empty list, ignored START, stalls, reset, optional abort).
module tb_lsm_address_generator;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LSM_START = 1'b0;
  logic [31:0] IR = '0;
  logic [31:0] BASE = '0;
  logic        LSM_NEXT = 1'b0;
`ifdef LSM_ABORT_EN
  logic        LSM_ABORT = 1'b0;
`endif
  logic [31:0] LSM_ADDR;
  logic        LSM_XFER;
  logic        LSM_LAST;
  logic [31:0] LSM_WB_VALUE;
  logic        LSM_WB_EN;
  logic        LSM_DONE;
  logic        LSM_BUSY;

  int n_cmp  = 0;
  int n_fail = 0;

  lsm_address_generator #(.ADDR_W(32)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .LSM_START    (LSM_START),
    .IR           (IR),
    .BASE         (BASE),
`ifdef LSM_ABORT_EN
    .LSM_ABORT    (LSM_ABORT),
`endif
    .LSM_NEXT     (LSM_NEXT),
    .LSM_ADDR     (LSM_ADDR),
    .LSM_XFER     (LSM_XFER),
    .LSM_LAST     (LSM_LAST),
    .LSM_WB_VALUE (LSM_WB_VALUE),
    .LSM_WB_EN    (LSM_WB_EN),
    .LSM_DONE     (LSM_DONE),
    .LSM_BUSY     (LSM_BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, LSM_ADDR, 32'h0);
    check({tag, "_xfer"}, {31'd0, LSM_XFER}, 32'h0);
    check({tag, "_last"}, {31'd0, LSM_LAST}, 32'h0);
    check({tag, "_wbv"},  LSM_WB_VALUE, 32'h0);
    check({tag, "_wben"}, {31'd0, LSM_WB_EN}, 32'h0);
    check({tag, "_done"}, {31'd0, LSM_DONE}, 32'h0);
    check({tag, "_busy"}, {31'd0, LSM_BUSY}, 32'h0);
  endtask

  // Pulse START for one edge; afterwards the DUT is in CALC.
  task automatic start_op(input string tag, input logic [31:0] ir, input logic [31:0] base);
    IR = ir;
    BASE = base;
    LSM_START = 1'b1;
    tick();
    LSM_START = 1'b0;
    check({tag, "_calc_busy"}, {31'd0, LSM_BUSY}, 32'h1);
    check({tag, "_calc_xfer"}, {31'd0, LSM_XFER}, 32'h0);
  endtask

  // Full operation with NEXT held high; expected address sequence ascends by 4.
  task automatic run_op(input string tag, input logic [31:0] ir, input logic [31:0] base,
                        input logic [31:0] first, input int n, input logic [31:0] wb,
                        input logic wben);
    logic [31:0] exp_addr;
    start_op(tag, ir, base);
    tick();
    check({tag, "_wbv"}, LSM_WB_VALUE, wb);
    exp_addr = first;
    for (int k = 0; k < n; k++) begin
      check({tag, "_addr"}, LSM_ADDR, exp_addr);
      check({tag, "_xfer"}, {31'd0, LSM_XFER}, 32'h1);
      check({tag, "_last"}, {31'd0, LSM_LAST}, (k == n - 1) ? 32'h1 : 32'h0);
      LSM_NEXT = 1'b1;
      tick();
      exp_addr = exp_addr + 32'd4;
    end
    LSM_NEXT = 1'b0;
    check({tag, "_done"}, {31'd0, LSM_DONE}, 32'h1);
    check({tag, "_wben"}, {31'd0, LSM_WB_EN}, {31'd0, wben});
    check({tag, "_done_xfer"}, {31'd0, LSM_XFER}, 32'h0);
    check({tag, "_done_busy"}, {31'd0, LSM_BUSY}, 32'h1);
    tick();
    check({tag, "_idle_done"}, {31'd0, LSM_DONE}, 32'h0);
    check({tag, "_idle_wben"}, {31'd0, LSM_WB_EN}, 32'h0);
    check({tag, "_idle_busy"}, {31'd0, LSM_BUSY}, 32'h0);
    check({tag, "_idle_wbv"}, LSM_WB_VALUE, wb);
  endtask

  initial begin
    // Reset state
    tick();
    check_idle_outputs("rst");
    RST_N = 1'b1;
    tick();
    check_idle_outputs("post_rst");

    // IA W=1, four registers
    run_op("ia", 32'h00A0_000F, 32'h0000_1000, 32'h0000_1000, 4, 32'h0000_1010, 1'b1);
    // DB W=1, r0 and r15
    run_op("db", 32'h0120_8001, 32'h0000_2000, 32'h0000_1FF8, 2, 32'h0000_1FF8, 1'b1);
    // IB W=0
    run_op("ib", 32'h0180_0101, 32'h0000_0100, 32'h0000_0104, 2, 32'h0000_0108, 1'b0);
    // DA W=0
    run_op("da", 32'h0000_0101, 32'h0000_0100, 32'h0000_00FC, 2, 32'h0000_00F8, 1'b0);
    // IA wrapping past the top of the address space
    run_op("wrap", 32'h00A0_0003, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, 32'h0000_0004, 1'b1);

    // Empty list: DONE at cycle 2, write-back value equals BASE
    start_op("empty", 32'h00A0_0000, 32'h0000_3000);
    tick();
    check("empty_done", {31'd0, LSM_DONE}, 32'h1);
    check("empty_wben", {31'd0, LSM_WB_EN}, 32'h1);
    check("empty_xfer", {31'd0, LSM_XFER}, 32'h0);
    check("empty_wbv", LSM_WB_VALUE, 32'h0000_3000);
    tick();
    check("empty_idle_busy", {31'd0, LSM_BUSY}, 32'h0);
    check("empty_idle_done", {31'd0, LSM_DONE}, 32'h0);

    // START during XFER is ignored
    start_op("ign", 32'h0000_0003 | 32'h0080_0000, 32'h0000_4000);
    tick();
    IR = 32'h0120_FFFF;
    BASE = 32'hDEAD_0000;
    LSM_START = 1'b1;
    tick();
    LSM_START = 1'b0;
    check("ign_addr", LSM_ADDR, 32'h0000_4000);
    check("ign_xfer", {31'd0, LSM_XFER}, 32'h1);
    check("ign_last", {31'd0, LSM_LAST}, 32'h0);
    check("ign_wbv", LSM_WB_VALUE, 32'h0000_4008);
    LSM_NEXT = 1'b1;
    tick();
    check("ign_addr2", LSM_ADDR, 32'h0000_4004);
    check("ign_last2", {31'd0, LSM_LAST}, 32'h1);
    tick();
    LSM_NEXT = 1'b0;
    check("ign_done", {31'd0, LSM_DONE}, 32'h1);
    check("ign_wben", {31'd0, LSM_WB_EN}, 32'h0);
    tick();
    check("ign_idle_busy", {31'd0, LSM_BUSY}, 32'h0);

    // NEXT held low: address holds; then reset mid-XFER
    start_op("stall", 32'h00A0_FFFF, 32'h0000_5000);
    tick();
    check("stall_wbv", LSM_WB_VALUE, 32'h0000_5040);
    check("stall_addr0", LSM_ADDR, 32'h0000_5000);
    LSM_NEXT = 1'b1;
    tick();
    LSM_NEXT = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_addr", LSM_ADDR, 32'h0000_5004);
      check("stall_xfer", {31'd0, LSM_XFER}, 32'h1);
    end
    #2;
    RST_N = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    tick();
    check_idle_outputs("rst_hold");
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_after_done", {31'd0, LSM_DONE}, 32'h0);
      check("rst_after_wben", {31'd0, LSM_WB_EN}, 32'h0);
      check("rst_after_busy", {31'd0, LSM_BUSY}, 32'h0);
    end

    // Recovery after reset
    run_op("recover", 32'h00A0_0001, 32'h0000_7000, 32'h0000_7000, 1, 32'h0000_7004, 1'b1);

`ifdef LSM_ABORT_EN
    // ABORT together with NEXT on the second transfer
    start_op("abort", 32'h00A0_0007, 32'h0000_6000);
    tick();
    check("abort_addr0", LSM_ADDR, 32'h0000_6000);
    LSM_NEXT = 1'b1;
    tick();
    check("abort_addr1", LSM_ADDR, 32'h0000_6004);
    LSM_ABORT = 1'b1;
    tick();
    LSM_ABORT = 1'b0;
    LSM_NEXT = 1'b0;
    check("abort_busy", {31'd0, LSM_BUSY}, 32'h0);
    check("abort_xfer", {31'd0, LSM_XFER}, 32'h0);
    check("abort_done", {31'd0, LSM_DONE}, 32'h0);
    check("abort_wben", {31'd0, LSM_WB_EN}, 32'h0);
    check("abort_wbv", LSM_WB_VALUE, 32'h0000_600C);
    tick();
    check("abort_after_done", {31'd0, LSM_DONE}, 32'h0);
    check("abort_after_wben", {31'd0, LSM_WB_EN}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_lsm_address_generator
